// File: rtl/video_dma_line_reader_if.sv
// UFI master bus between the frame-buffer DMA reader and the external RAM controller.
interface video_dma_line_reader_if #(
  parameter int pUfiAdrsBusWidth = 32,
  parameter int pUfiDqBusWidth   = 16
) ();
  logic [pUfiAdrsBusWidth-1:0] oMUfiAdrs;
  logic                        oMUfiReq;
  logic                        iMUfiRdy;
  logic [pUfiDqBusWidth-1:0]   iMUfiRd;
  logic                        iMUfiRvd;

  modport master (output oMUfiAdrs, oMUfiReq, input iMUfiRdy, iMUfiRd, iMUfiRvd);
  modport slave  (input oMUfiAdrs, oMUfiReq, output iMUfiRdy, iMUfiRd, iMUfiRvd);
endinterface

// File: rtl/video_dma_line_reader.sv
// Frame-buffer DMA reader: UFI bursts -> 32-bit pixels -> sync pixel FIFO.
// Optional VDMA_WORD_SWAP_EN puts the first word of each pair in pixel[31:16].
module video_dma_line_reader #(
  parameter int         pUfiDqBusWidth   = 16,
  parameter int         pUfiAdrsBusWidth = 32,
  parameter logic [3:0] pUfiAdrsMap      = 4'h2,
  parameter int         pDmaAdrsWidth    = 18,
  parameter int         pDmaBurstLength  = 256,
  parameter int         pColorDepth      = 32,
  parameter int         pFifoDepth       = 512
) (
  input  logic                     iSCLK,
  input  logic                     iSRST,
  input  logic                     iDmaEnable,
  input  logic                     iDmaCycleEnable,
  input  logic [pDmaAdrsWidth-1:0] iDmaAdrsStart,
  input  logic [pDmaAdrsWidth-1:0] iDmaAdrsEnd,
  input  logic [pDmaAdrsWidth-1:0] iDmaAdrsAdd,
  output logic                     oDmaDone,
  video_dma_line_reader_if.master  ufi,
  output logic [pColorDepth-1:0]   oRd,
  input  logic                     iRe,
  output logic                     oRvd,
  output logic                     oEmp
);

  localparam int PtrW = $clog2(pFifoDepth);
  localparam int CntW = PtrW + 1;
  localparam int WcW  = $clog2(pDmaBurstLength);
  localparam int PadW = pUfiAdrsBusWidth - 4 - pDmaAdrsWidth;
  localparam logic [CntW-1:0] FifoDepthC = CntW'(pFifoDepth);
  localparam logic [CntW-1:0] PixPerBurst = CntW'(pDmaBurstLength / 2);
  localparam logic [WcW-1:0]  LastWord = WcW'(pDmaBurstLength - 1);

  typedef enum logic [1:0] {IDLE, REQ, BURST, NEXT} state_t;

  state_t                        state_q, state_d;
  logic [pDmaAdrsWidth-1:0]      adrs_q, adrs_d;
  logic [pUfiAdrsBusWidth-1:0]   ufi_adrs_q, ufi_adrs_d;
  logic                          req_q, req_d;
  logic                          done_q, done_d;
  logic [WcW-1:0]                wcnt_q, wcnt_d;
  logic [pUfiDqBusWidth-1:0]     half_q, half_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]               count_q, count_d;
  logic [pColorDepth-1:0]        rd_data_q, rd_data_d;
  logic                          rvd_q, rvd_d;

  logic [pColorDepth-1:0]        fifo_mem [pFifoDepth];
  logic                          push, pop, accept, eof;
  logic [pColorDepth-1:0]        push_data;
  logic [CntW-1:0]               free_space;
  logic [pDmaAdrsWidth:0]        next_sum;

  always_comb begin
    state_d    = state_q;
    adrs_d     = adrs_q;
    ufi_adrs_d = ufi_adrs_q;
    req_d      = req_q;
    done_d     = 1'b0;
    wcnt_d     = wcnt_q;
    half_d     = half_q;
    push       = 1'b0;

    pop        = iRe && (count_q != '0);
    free_space = FifoDepthC - count_q;
    accept     = req_q && ufi.iMUfiRdy;
    next_sum   = {1'b0, adrs_q} + {1'b0, iDmaAdrsAdd};
    // The carry bit catches a step that runs past the top of the DMA address space.
    eof        = next_sum[pDmaAdrsWidth] || (next_sum[pDmaAdrsWidth-1:0] > iDmaAdrsEnd);

`ifdef VDMA_WORD_SWAP_EN
    push_data = {half_q, ufi.iMUfiRd};
`else
    push_data = {ufi.iMUfiRd, half_q};
`endif

    case (state_q)
      IDLE: begin
        if (iDmaEnable) begin
          adrs_d  = iDmaAdrsStart;
          state_d = REQ;
        end
      end
      REQ: begin
        if (accept) begin
          req_d   = 1'b0;
          wcnt_d  = '0;
          state_d = BURST;
        end else if (free_space >= PixPerBurst) begin
          req_d      = 1'b1;
          ufi_adrs_d = {pUfiAdrsMap, {PadW{1'b0}}, adrs_q};
        end
      end
      BURST: begin
        if (ufi.iMUfiRvd) begin
          wcnt_d = wcnt_q + 1'b1;
          if (!wcnt_q[0]) half_d = ufi.iMUfiRd;
          else            push   = 1'b1;
          if (wcnt_q == LastWord) state_d = NEXT;
        end
      end
      NEXT: begin
        done_d = eof;
        if (eof) begin
          if (iDmaCycleEnable && iDmaEnable) begin
            adrs_d  = iDmaAdrsStart;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          adrs_d  = next_sum[pDmaAdrsWidth-1:0];
          state_d = iDmaEnable ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d = pop  ? fifo_mem[rd_ptr_q] : rd_data_q;
    rvd_d     = pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge iSCLK) begin
    if (iSRST) begin
      state_q    <= IDLE;
      adrs_q     <= '0;
      ufi_adrs_q <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= '0;
      half_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rvd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adrs_q     <= adrs_d;
      ufi_adrs_q <= ufi_adrs_d;
      req_q      <= req_d;
      done_q     <= done_d;
      wcnt_q     <= wcnt_d;
      half_q     <= half_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rvd_q      <= rvd_d;
    end
  end

  // Pixel storage has no reset; the pointers define what is valid.
  always_ff @(posedge iSCLK) begin
    if (!iSRST && push) begin
      assert (count_q != FifoDepthC);
      fifo_mem[wr_ptr_q] <= push_data;
    end
  end

  assign ufi.oMUfiAdrs = ufi_adrs_q;
  assign ufi.oMUfiReq  = req_q;
  assign oDmaDone      = done_q;
  assign oRd           = rd_data_q;
  assign oRvd          = rvd_q;
  assign oEmp          = (count_q == '0);

endmodule

// File: tb/tb_video_dma_line_reader.sv
// Directed self-checking bench for video_dma_line_reader (honours VDMA_WORD_SWAP_EN).
module tb_video_dma_line_reader;

  logic        clk;
  logic        rst;
  logic        en, cyc;
  logic [17:0] adrsStart, adrsEnd, adrsAdd;
  logic        dmaDone;
  logic [31:0] rd;
  logic        re;
  logic        rvd;
  logic        emp;

  int compared;
  int mismatched;
  logic [31:0] pixQ [$];

  video_dma_line_reader_if ufi ();

  video_dma_line_reader dut (
    .iSCLK           (clk),
    .iSRST           (rst),
    .iDmaEnable      (en),
    .iDmaCycleEnable (cyc),
    .iDmaAdrsStart   (adrsStart),
    .iDmaAdrsEnd     (adrsEnd),
    .iDmaAdrsAdd     (adrsAdd),
    .oDmaDone        (dmaDone),
    .ufi             (ufi.master),
    .oRd             (rd),
    .iRe             (re),
    .oRvd            (rvd),
    .oEmp            (emp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [15:0] wordOf(input int b, input int i);
    if (i == 0) return 16'h5678;
    if (i == 1) return 16'h1234;
    return 16'((b << 12) | i);
  endfunction

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4);
    rst = 1'b0;
    pixQ.delete();
  endtask

  task automatic waitReq(input string tag, input int budget);
    int n;
    n = 0;
    while (!ufi.oMUfiReq && n < budget) begin
      applyStimulus(1);
      n++;
    end
    checkOutput({tag, "_req"}, {31'd0, ufi.oMUfiReq}, 32'd1);
  endtask

  task automatic serveBurst(input string tag, input int b, input logic [31:0] expAdrs, input bit dropEnable);
    logic [15:0] lo, w;
    lo = '0;
    waitReq(tag, 600);
    checkOutput({tag, "_adrs"}, ufi.oMUfiAdrs, expAdrs);
    ufi.iMUfiRdy = 1'b1;
    applyStimulus(1);
    ufi.iMUfiRdy = 1'b0;
    checkOutput({tag, "_req_drop"}, {31'd0, ufi.oMUfiReq}, 32'd0);
    if (dropEnable) en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = wordOf(b, i);
      if (i % 2 == 0) lo = w;
`ifdef VDMA_WORD_SWAP_EN
      else pixQ.push_back({lo, w});
`else
      else pixQ.push_back({w, lo});
`endif
      ufi.iMUfiRd  = w;
      ufi.iMUfiRvd = 1'b1;
      applyStimulus(1);
    end
    ufi.iMUfiRvd = 1'b0;
  endtask

  task automatic countDone(input string tag, input int expected);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      if (dmaDone) pulses++;
    end
    checkOutput({tag, "_done_pulses"}, 32'(pulses), 32'(expected));
  endtask

  task automatic readPixel(input string tag);
    logic [31:0] exp;
    re = 1'b1;
    applyStimulus(1);
    re = 1'b0;
    exp = (pixQ.size() > 0) ? pixQ.pop_front() : 32'hDEAD_BEEF;
    checkOutput({tag, "_rvd"}, {31'd0, rvd}, 32'd1);
    checkOutput({tag, "_data"}, rd, exp);
  endtask

  task automatic drain(input string tag);
    int n, want;
    n = 0;
    want = pixQ.size();
    while (!emp && n < 1000) begin
      readPixel(tag);
      n++;
    end
    checkOutput({tag, "_count"}, 32'(n), 32'(want));
  endtask

  initial begin
    logic [31:0] firstPix;
    int seen;
    compared   = 0;
    mismatched = 0;
    rst = 1'b1; en = 1'b0; cyc = 1'b0; re = 1'b0;
    adrsStart = 18'h100; adrsEnd = 18'h300; adrsAdd = 18'h100;
    ufi.iMUfiRdy = 1'b0; ufi.iMUfiRd = '0; ufi.iMUfiRvd = 1'b0;
`ifdef VDMA_WORD_SWAP_EN
    firstPix = 32'h5678_1234;
`else
    firstPix = 32'h1234_5678;
`endif

    $display("[TB] reset values");
    doReset();
    checkOutput("rst_req", {31'd0, ufi.oMUfiReq}, 32'd0);
    checkOutput("rst_adrs", ufi.oMUfiAdrs, 32'd0);
    checkOutput("rst_done", {31'd0, dmaDone}, 32'd0);
    checkOutput("rst_rvd", {31'd0, rvd}, 32'd0);
    checkOutput("rst_rd", rd, 32'd0);
    checkOutput("rst_emp", {31'd0, emp}, 32'd1);

    $display("[TB] reset mid-burst");
    en = 1'b1;
    waitReq("mid", 20);
    ufi.iMUfiRdy = 1'b1;
    applyStimulus(1);
    ufi.iMUfiRdy = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ufi.iMUfiRd = wordOf(0, i); ufi.iMUfiRvd = 1'b1;
      applyStimulus(1);
    end
    checkOutput("mid_emp_before", {31'd0, emp}, 32'd0);
    rst = 1'b1;
    applyStimulus(4);
    rst = 1'b0;
    checkOutput("mid_rst_req", {31'd0, ufi.oMUfiReq}, 32'd0);
    checkOutput("mid_rst_adrs", ufi.oMUfiAdrs, 32'd0);
    checkOutput("mid_rst_rd", rd, 32'd0);
    checkOutput("mid_rst_emp", {31'd0, emp}, 32'd1);
    applyStimulus(4);
    ufi.iMUfiRvd = 1'b0;
    checkOutput("mid_stray_emp", {31'd0, emp}, 32'd1);
    checkOutput("mid_stray_req", {31'd0, ufi.oMUfiReq}, 32'd0);

    $display("[TB] single frame, cycle off");
    doReset();
    en = 1'b1; cyc = 1'b0;
    serveBurst("f0b0", 0, 32'h2000_0100, 1'b0);
    countDone("f0b0", 0);
    serveBurst("f0b1", 1, 32'h2000_0200, 1'b0);
    countDone("f0b1", 0);
    serveBurst("f0b2", 2, 32'h2000_0300, 1'b1);
    countDone("f0b2", 1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1);
      if (ufi.oMUfiReq) seen++;
    end
    checkOutput("f0_idle_no_req", 32'(seen), 32'd0);
    re = 1'b1;
    applyStimulus(1);
    re = 1'b0;
    checkOutput("first_pix_rvd", {31'd0, rvd}, 32'd1);
    checkOutput("first_pix_data", rd, firstPix);
    void'(pixQ.pop_front());
    applyStimulus(1);
    checkOutput("rvd_drops", {31'd0, rvd}, 32'd0);
    drain("f0_drain");
    re = 1'b1;
    applyStimulus(1);
    re = 1'b0;
    checkOutput("empty_re_rvd", {31'd0, rvd}, 32'd0);
    checkOutput("empty_re_emp", {31'd0, emp}, 32'd1);

    $display("[TB] cycle on, free-space gating");
    doReset();
    en = 1'b1; cyc = 1'b1;
    serveBurst("c0b0", 0, 32'h2000_0100, 1'b0);
    countDone("c0b0", 0);
    serveBurst("c0b1", 1, 32'h2000_0200, 1'b0);
    countDone("c0b1", 0);
    serveBurst("c0b2", 2, 32'h2000_0300, 1'b0);
    countDone("c0b2", 1);
    serveBurst("c1b0", 3, 32'h2000_0100, 1'b0);
    countDone("c1b0", 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1);
      if (ufi.oMUfiReq) seen++;
    end
    checkOutput("full_no_req", 32'(seen), 32'd0);
    for (int i = 0; i < 127; i++) readPixel("full_rd");
    applyStimulus(3);
    checkOutput("free127_no_req", {31'd0, ufi.oMUfiReq}, 32'd0);
    readPixel("free128_rd");
    waitReq("free128", 5);
    checkOutput("free128_adrs", ufi.oMUfiAdrs, 32'h2000_0200);
    en = 1'b0;

    $display("[TB] address carry ends the frame");
    doReset();
    adrsStart = 18'h3FF00; adrsAdd = 18'h200; adrsEnd = 18'h3FFFF;
    en = 1'b1; cyc = 1'b1;
    serveBurst("carry_b0", 0, 32'h2003_FF00, 1'b0);
    countDone("carry_b0", 1);
    waitReq("carry_restart", 10);
    checkOutput("carry_restart_adrs", ufi.oMUfiAdrs, 32'h2003_FF00);
    en = 1'b0;
    doReset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
